// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcodes, ALUOP codes, instruction field offsets and decode-stage states shared across the CPU
package cpu_isa_pkg;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_AND   = 8'd2;
    localparam logic [7:0] OP_OR    = 8'd3;
    localparam logic [7:0] OP_ADD   = 8'd4;
    localparam logic [7:0] OP_SUB   = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;
    localparam logic [7:0] OP_BNE   = 8'd12;
    localparam logic [7:0] OP_SLL   = 8'd13;
    localparam logic [7:0] OP_SRL   = 8'd14;

    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;

    localparam int OPC_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_HOLD      = 2'd1,
        ST_MEM_STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic       we;
        logic       loadi;
        logic       sub;
        logic [2:0] aluop;
        logic       j;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: pure combinational opcode to control-select table
module decode_comb
    import cpu_isa_pkg::*;
(
    input  logic [7:0] opcode,
    output ctrl_t      ctrl
);

    // unlisted opcodes leave every select low and raise illegal
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LOADI: begin ctrl.we = 1'b1; ctrl.loadi = 1'b1; end
            OP_MOV:   ctrl.we = 1'b1;
            OP_AND:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_AND; end
            OP_OR:    begin ctrl.we = 1'b1; ctrl.aluop = ALU_OR; end
            OP_ADD:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_ADD; end
            OP_SUB:   begin ctrl.we = 1'b1; ctrl.sub = 1'b1; ctrl.aluop = ALU_ADD; end
            OP_J:     ctrl.j = 1'b1;
            OP_BEQ:   begin ctrl.sub = 1'b1; ctrl.aluop = ALU_ADD; ctrl.beq = 1'b1; end
            OP_LWD:   begin ctrl.we = 1'b1; ctrl.mem_read = 1'b1; end
            OP_LWI:   begin ctrl.we = 1'b1; ctrl.loadi = 1'b1; ctrl.mem_read = 1'b1; end
            OP_SWD:   ctrl.mem_write = 1'b1;
            OP_SWI:   begin ctrl.loadi = 1'b1; ctrl.mem_write = 1'b1; end
            OP_BNE:   begin ctrl.sub = 1'b1; ctrl.aluop = ALU_ADD; ctrl.bne = 1'b1; end
            OP_SLL:   begin ctrl.we = 1'b1; ctrl.loadi = 1'b1; ctrl.aluop = ALU_SLL; end
            OP_SRL:   begin ctrl.we = 1'b1; ctrl.loadi = 1'b1; ctrl.aluop = ALU_SRL; end
            default:  ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: registered, handshaked decode stage with memory-stall hold, flush and illegal counter
module decode_stage_pipelined
    import cpu_isa_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 3,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             INSTRUCTION,
    input  logic                    INSTR_VALID,
    output logic                    INSTR_READY,
    input  logic                    FLUSH,
    input  logic                    MEM_BUSYWAIT,
    input  logic                    OUT_READY,
    output logic                    OUT_VALID,
    output logic [7:0]              OPCODE,
    output logic signed [7:0]       DESTINATION,
    output logic [7:0]              IMMEDIATE,
    output logic [REG_ADDR_W-1:0]   READREG1,
    output logic [REG_ADDR_W-1:0]   READREG2,
    output logic [REG_ADDR_W-1:0]   WRITEREG,
    output logic [ALUOP_W-1:0]      ALUOP,
    output logic                    WRITEENABLE,
    output logic                    LOADI_SEL,
    output logic                    SUB_SEL,
    output logic                    J_SEL,
    output logic                    BEQ_SEL,
    output logic                    BNE_SEL,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic                    ILLEGAL,
    output logic [ILL_CNT_W-1:0]    ILL_COUNT
);

    if (REG_ADDR_W < 1 || REG_ADDR_W > 8 || ALUOP_W < 3) begin : g_bad_params
        $error("decode_stage_pipelined: REG_ADDR_W must be 1..8 and ALUOP_W >= 3");
    end

    state_t                 state_q, state_d;
    ctrl_t                  ctrl_q, ctrl_d, dec;
    logic [7:0]             opc_q, opc_d, dst_q, dst_d, imm_q, imm_d;
    logic [REG_ADDR_W-1:0]  rr1_q, rr1_d;
    logic [ILL_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   mem_op, retire, accept;

    decode_comb u_decode_comb (
        .opcode (INSTRUCTION[OPC_LSB +: 8]),
        .ctrl   (dec)
    );

    // a memory op cannot leave while memory is busy; in MEM_STALL nothing retires until back in HOLD
    assign mem_op      = ctrl_q.mem_read | ctrl_q.mem_write;
    assign retire      = (state_q == ST_HOLD) && OUT_READY && !(mem_op && MEM_BUSYWAIT);
    assign INSTR_READY = (state_q == ST_EMPTY) || retire;
    assign accept      = INSTR_VALID && INSTR_READY && !FLUSH;

    // FSM transitions, payload capture/clear and saturating illegal count
    always_comb begin
        state_d = FLUSH ? ST_EMPTY :
                  (state_q == ST_EMPTY) ? (accept ? ST_HOLD : ST_EMPTY) :
                  (state_q == ST_MEM_STALL) ? (MEM_BUSYWAIT ? ST_MEM_STALL : ST_HOLD) :
                  retire ? (accept ? ST_HOLD : ST_EMPTY) :
                  (mem_op && MEM_BUSYWAIT) ? ST_MEM_STALL : ST_HOLD;
        {opc_d, dst_d, imm_d, rr1_d, ctrl_d} = accept ?
            {INSTRUCTION[OPC_LSB +: 8], INSTRUCTION[DST_LSB +: 8], INSTRUCTION[SRC2_LSB +: 8],
             INSTRUCTION[SRC1_LSB +: REG_ADDR_W], dec} :
            (state_d == ST_EMPTY) ? '0 : {opc_q, dst_q, imm_q, rr1_q, ctrl_q};
        cnt_d = cnt_q + ILL_CNT_W'(accept && dec.illegal && (cnt_q != '1));
    end

    // state and decoded payload registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_EMPTY;
            ctrl_q  <= '0;
            opc_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            rr1_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            opc_q   <= opc_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            rr1_q   <= rr1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OUT_VALID   = state_q != ST_EMPTY;
    assign OPCODE      = opc_q;
    assign DESTINATION = dst_q;
    assign IMMEDIATE   = imm_q;
    assign READREG1    = rr1_q;
    assign READREG2    = imm_q[REG_ADDR_W-1:0];
    assign WRITEREG    = dst_q[REG_ADDR_W-1:0];
    assign ALUOP       = ALUOP_W'(ctrl_q.aluop);
    assign WRITEENABLE = ctrl_q.we;
    assign LOADI_SEL   = ctrl_q.loadi;
    assign SUB_SEL     = ctrl_q.sub;
    assign J_SEL       = ctrl_q.j;
    assign BEQ_SEL     = ctrl_q.beq;
    assign BNE_SEL     = ctrl_q.bne;
    assign MEM_READ    = ctrl_q.mem_read;
    assign MEM_WRITE   = ctrl_q.mem_write;
    assign ILLEGAL     = ctrl_q.illegal;
    assign ILL_COUNT   = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb_decode_stage_pipelined: directed and randomized checks against a behavioural decode-stage model
module tb_decode_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        iv, fl, busy, ordy;
    logic        instr_ready, out_valid;
    logic [7:0]  opcode, immediate;
    logic signed [7:0] destination;
    logic [2:0]  rr1, rr2, wr, aluop;
    logic        we, loadi, sub, j, beq, bne, mrd, mwr, ill;
    logic [7:0]  ill_count;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: held instruction, stalled flag, illegal count
    bit          m_v, m_st;
    logic [31:0] m_i;
    int          m_cnt;

    // {we,loadi,sub,aluop[2:0],j,beq,bne,mem_read,mem_write,illegal} per opcode 0..14
    localparam logic [11:0] TBL [15] = '{
        12'b110_000_000000, 12'b100_000_000000, 12'b100_010_000000, 12'b100_011_000000,
        12'b100_001_000000, 12'b101_001_000000, 12'b000_000_100000, 12'b001_001_010000,
        12'b100_000_000100, 12'b110_000_000100, 12'b000_000_000010, 12'b010_000_000010,
        12'b001_001_001000, 12'b110_101_000000, 12'b110_110_000000
    };

    always #5 clk = ~clk;

    decode_stage_pipelined dut (
        .CLK(clk), .RESET(rst_n), .INSTRUCTION(instr), .INSTR_VALID(iv), .INSTR_READY(instr_ready),
        .FLUSH(fl), .MEM_BUSYWAIT(busy), .OUT_READY(ordy), .OUT_VALID(out_valid),
        .OPCODE(opcode), .DESTINATION(destination), .IMMEDIATE(immediate),
        .READREG1(rr1), .READREG2(rr2), .WRITEREG(wr), .ALUOP(aluop),
        .WRITEENABLE(we), .LOADI_SEL(loadi), .SUB_SEL(sub), .J_SEL(j), .BEQ_SEL(beq), .BNE_SEL(bne),
        .MEM_READ(mrd), .MEM_WRITE(mwr), .ILLEGAL(ill), .ILL_COUNT(ill_count)
    );

    function automatic logic [11:0] ref_ctrl(input logic [7:0] op);
        return (op > 8'd14) ? 12'b000_000_000001 : TBL[int'(op)];
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(m_v));
        check("ctrl", 64'({we, loadi, sub, aluop, j, beq, bne, mrd, mwr, ill}),
              64'(m_v ? ref_ctrl(m_i[31:24]) : 12'd0));
        if (m_v)
            check("fields", 64'({opcode, destination, immediate, rr1, rr2, wr}),
                  64'({m_i[31:16], m_i[7:0], m_i[10:8], m_i[2:0], m_i[18:16]}));
        check("ill_count", 64'(ill_count), 64'(m_cnt));
    endtask

    // one cycle: drive at negedge, check ready, clock, advance model, check registered outputs
    task automatic step(input bit s_iv, input logic [31:0] s_ins, input bit s_fl, input bit s_busy, input bit s_ordy);
        bit e_mem, e_ret, e_rdy, acc;
        @(negedge clk);
        iv = s_iv; instr = s_ins; fl = s_fl; busy = s_busy; ordy = s_ordy;
        #1;
        e_mem = m_v && (ref_ctrl(m_i[31:24]) & 12'b000_000_000110) != 0;
        e_ret = m_v && !m_st && s_ordy && !(e_mem && s_busy);
        e_rdy = !m_v || e_ret;
        acc   = s_iv && e_rdy && !s_fl;
        check("instr_ready", 64'(instr_ready), 64'(e_rdy));
        @(posedge clk);
        if (s_fl) begin m_v = 0; m_st = 0; end
        else if (m_st) m_st = s_busy;
        else if (e_ret) m_v = acc;
        else if (m_v) begin if (e_mem && s_busy) m_st = 1; end
        else m_v = acc;
        if (acc) begin
            m_i = s_ins;
            if (s_ins[31:24] > 8'd14 && m_cnt < 255) m_cnt++;
        end
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        m_v = 0; m_st = 0; m_i = '0; m_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; iv = 0; instr = '0; fl = 0; busy = 0; ordy = 0;
        model_reset();
        #3;
        check_outputs();
        check("reset_ready", 64'(instr_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        step(1, 32'h04020103, 0, 0, 1);
        check("add_aluop", 64'(aluop), 64'd1);
        check("add_regs", 64'({we, wr, rr1, rr2}), 64'({1'b1, 3'd2, 3'd1, 3'd3}));

        step(1, 32'h05030201, 0, 0, 1);
        step(1, 32'h07FE0102, 0, 0, 1);
        check("beq_sel", 64'({sub, beq, bne}), 64'b110);
        step(1, 32'h0C040304, 0, 0, 1);
        check("bne_sel", 64'({sub, beq, bne}), 64'b101);

        step(1, 32'h08050002, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 32'h01000000, 0, 1, 1);
        step(1, 32'h01000000, 0, 0, 1);
        check("lwd_still_held", 64'({out_valid, mrd, opcode}), 64'({1'b1, 1'b1, 8'h08}));
        step(0, 32'h0, 0, 0, 1);

        step(1, 32'h04010203, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h03070605, 0, 0, 0);
        step(1, 32'h03070605, 0, 0, 1);
        check("next_fetch_or", 64'(opcode), 64'h03);

        step(1, 32'hFF000000, 1, 0, 1);
        check("flush_drop", 64'({out_valid, ill_count}), 64'd0);

        for (int i = 0; i < 300; i++) step(1, {8'(15 + i % 241), 24'($urandom)}, 0, 0, 1);
        check("ill_saturate", 64'(ill_count), 64'd255);

        step(1, 32'h0D123456, 0, 0, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("async_reset_fields", 64'({opcode, destination, immediate, aluop}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, {8'($urandom_range(0, 17)), 24'($urandom)},
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
